// File: rtl/simt_stack_if.sv
// Request/response channel between an issue unit and the SIMT reconvergence stack.
interface simt_stack_if #(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
);
  localparam int TPB = THREADS_PER_BLOCK;
  localparam int PCW = PROGRAM_MEM_ADDR_BITS;

  logic           req_valid;
  logic           req_ready;
  logic           req_type;
  logic [PCW-1:0] req_pc;
  logic [TPB-1:0] taken_mask;
  logic [PCW-1:0] taken_pc;
  logic [PCW-1:0] not_taken_pc;
  logic [PCW-1:0] reconv_pc;
  logic           resp_valid;
  logic [PCW-1:0] resp_pc;
  logic           resp_error;

  modport master (
    output req_valid, req_type, req_pc, taken_mask, taken_pc, not_taken_pc, reconv_pc,
    input  req_ready, resp_valid, resp_pc, resp_error
  );

  modport slave (
    input  req_valid, req_type, req_pc, taken_mask, taken_pc, not_taken_pc, reconv_pc,
    output req_ready, resp_valid, resp_pc, resp_error
  );
endinterface

// File: rtl/simt_stack.sv
// SIMT divergence/reconvergence stack: branches push {mask,pc} pairs, syncs pop them.
module simt_stack #(
  parameter int THREADS_PER_BLOCK     = 4,
  parameter int STACK_DEPTH           = 4,
  parameter int PROGRAM_MEM_ADDR_BITS = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [$clog2(THREADS_PER_BLOCK):0] thread_count,
  simt_stack_if.slave                       bus,
  output logic [THREADS_PER_BLOCK-1:0]      active_mask,
  output logic [$clog2(STACK_DEPTH):0]      stack_depth,
  output logic                              overflow
);
  localparam int TPB = THREADS_PER_BLOCK;
  localparam int PCW = PROGRAM_MEM_ADDR_BITS;
  localparam int AW  = $clog2(STACK_DEPTH);
  localparam int DW  = AW + 1;

  typedef struct packed {
    logic [TPB-1:0] mask;
    logic [PCW-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {IDLE, PUSH2, RESP} state_t;

  state_t         state, nxt;
  entry_t         stack [STACK_DEPTH];
  entry_t         top, push_entry;
  logic [TPB-1:0] init_mask, t_mask, nt_mask;
  logic [TPB-1:0] pend_t, pend_nt;
  logic [PCW-1:0] pend_tpc, pend_ntpc;
  logic           accept, fits, div, div_ok, push_en;

  for (genvar i = 0; i < TPB; i++) begin : g_lane
    assign init_mask[i] = int'(thread_count) > i;
  end

  assign t_mask  = bus.taken_mask & active_mask;
  assign nt_mask = active_mask & ~bus.taken_mask;

  assign bus.req_ready  = (state == IDLE) && !start;
  assign bus.resp_valid = (state == RESP);

  assign accept = bus.req_valid && bus.req_ready;
  assign fits   = stack_depth <= DW'(STACK_DEPTH - 2);
  assign div    = !bus.req_type && (|t_mask) && (|nt_mask);
  assign div_ok = div && fits;

  // A divergent branch spends two cycles writing the single-ported stack:
  // the reconvergence entry on accept, then the not-taken entry in PUSH2.
  assign push_en    = !start && ((accept && div_ok) || (state == PUSH2));
  assign push_entry = (state == PUSH2) ? entry_t'{pend_nt, pend_ntpc}
                                       : entry_t'{active_mask, bus.reconv_pc};
  assign top        = stack[AW'(stack_depth - DW'(1))];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = div_ok ? PUSH2 : RESP;
      PUSH2:   nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (start) nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (push_en) stack[AW'(stack_depth)] <= push_entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_mask    <= '0;
      stack_depth    <= '0;
      overflow       <= 1'b0;
      bus.resp_pc    <= '0;
      bus.resp_error <= 1'b0;
      pend_t         <= '0;
      pend_nt        <= '0;
      pend_tpc       <= '0;
      pend_ntpc      <= '0;
    end else if (start) begin
      active_mask <= init_mask;
      stack_depth <= '0;
      overflow    <= 1'b0;
    end else if (accept) begin
      bus.resp_error <= 1'b0;
      if (bus.req_type) begin
        if (stack_depth != '0) begin
          active_mask <= top.mask;
          bus.resp_pc <= top.pc;
          stack_depth <= stack_depth - DW'(1);
        end else begin
          bus.resp_pc <= bus.req_pc + PCW'(1);
        end
      end else if (nt_mask == '0) begin
        bus.resp_pc <= bus.taken_pc;
      end else if (t_mask == '0) begin
        bus.resp_pc <= bus.not_taken_pc;
      end else if (fits) begin
        // Response registers keep the previous answer until PUSH2 completes.
        stack_depth <= stack_depth + DW'(1);
        pend_t      <= t_mask;
        pend_nt     <= nt_mask;
        pend_tpc    <= bus.taken_pc;
        pend_ntpc   <= bus.not_taken_pc;
      end else begin
        bus.resp_pc    <= bus.not_taken_pc;
        bus.resp_error <= 1'b1;
        overflow       <= 1'b1;
      end
    end else if (state == PUSH2) begin
      stack_depth    <= stack_depth + DW'(1);
      active_mask    <= pend_t;
      bus.resp_pc    <= pend_tpc;
      bus.resp_error <= 1'b0;
    end
  end
endmodule

// File: tb/tb_simt_stack.sv
// Directed bench for simt_stack: reset, start masks, uniform/divergent branches, syncs, overflow, start aborts.
module tb_simt_stack;
  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] thread_count;
  logic [3:0] active_mask;
  logic [2:0] stack_depth;
  logic       overflow;
  int         checks;
  int         errors;

  simt_stack_if #(.THREADS_PER_BLOCK(4), .PROGRAM_MEM_ADDR_BITS(8)) bus ();

  simt_stack #(.THREADS_PER_BLOCK(4), .STACK_DEPTH(4), .PROGRAM_MEM_ADDR_BITS(8)) dut (
    .clk(clk), .reset(reset), .start(start), .thread_count(thread_count),
    .bus(bus), .active_mask(active_mask), .stack_depth(stack_depth), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] tc);
    start = 1'b1;
    thread_count = tc;
    tick();
    start = 1'b0;
  endtask

  // Presents one request for one cycle; returns just after the accept edge (cycle N+1).
  task automatic send(input logic typ, input logic [7:0] rpc, input logic [3:0] tm,
                      input logic [7:0] tpc, input logic [7:0] ntpc, input logic [7:0] rcpc);
    bus.req_type = typ;
    bus.req_pc = rpc;
    bus.taken_mask = tm;
    bus.taken_pc = tpc;
    bus.not_taken_pc = ntpc;
    bus.reconv_pc = rcpc;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (active_mask !== 4'b0000) begin errors++; $display("FAIL rst_mask: got %b want 0000", active_mask); end
    checks++; if (stack_depth !== 3'd0) begin errors++; $display("FAIL rst_depth: got %0d want 0", stack_depth); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.resp_valid); end
    checks++; if (bus.resp_pc !== 8'd0) begin errors++; $display("FAIL rst_pc: got %0d want 0", bus.resp_pc); end
    checks++; if (bus.resp_error !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", bus.resp_error); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", overflow); end
    reset = 1'b1;
    tick();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_start_mask();
    do_start(3'd3);
    checks++; if (active_mask !== 4'b0111) begin errors++; $display("FAIL start_tc3: got %b want 0111", active_mask); end
    do_start(3'd0);
    checks++; if (active_mask !== 4'b0000) begin errors++; $display("FAIL start_tc0: got %b want 0000", active_mask); end
    do_start(3'd7);
    checks++; if (active_mask !== 4'b1111) begin errors++; $display("FAIL start_tc7: got %b want 1111", active_mask); end
    do_start(3'd1);
    checks++; if (active_mask !== 4'b0001) begin errors++; $display("FAIL start_tc1: got %b want 0001", active_mask); end
  endtask

  task automatic test_uniform();
    do_start(3'd4);
    send(1'b0, 8'd2, 4'b1111, 8'd9, 8'd3, 8'd0);
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL uni_valid: got %b want 1", bus.resp_valid); end
    checks++; if (bus.resp_pc !== 8'd9) begin errors++; $display("FAIL uni_pc: got %0d want 9", bus.resp_pc); end
    checks++; if (active_mask !== 4'b1111) begin errors++; $display("FAIL uni_mask: got %b want 1111", active_mask); end
    checks++; if (stack_depth !== 3'd0) begin errors++; $display("FAIL uni_depth: got %0d want 0", stack_depth); end
    tick();
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL uni_pulse: got %b want 0", bus.resp_valid); end
    checks++; if (bus.resp_pc !== 8'd9) begin errors++; $display("FAIL uni_hold: got %0d want 9", bus.resp_pc); end
    send(1'b0, 8'd3, 4'b0000, 8'd9, 8'd21, 8'd0);
    checks++; if (bus.resp_pc !== 8'd21) begin errors++; $display("FAIL uni_nt_pc: got %0d want 21", bus.resp_pc); end
    checks++; if (active_mask !== 4'b1111) begin errors++; $display("FAIL uni_nt_mask: got %b want 1111", active_mask); end
    tick();
  endtask

  task automatic test_divergence();
    do_start(3'd4);
    send(1'b0, 8'd5, 4'b0011, 8'd9, 8'd6, 8'd10);
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL div_early: got %b want 0", bus.resp_valid); end
    checks++; if (stack_depth !== 3'd1) begin errors++; $display("FAIL div_push1: got %0d want 1", stack_depth); end
    tick();
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL div_valid: got %b want 1", bus.resp_valid); end
    checks++; if (bus.resp_pc !== 8'd9) begin errors++; $display("FAIL div_pc: got %0d want 9", bus.resp_pc); end
    checks++; if (active_mask !== 4'b0011) begin errors++; $display("FAIL div_mask: got %b want 0011", active_mask); end
    checks++; if (stack_depth !== 3'd2) begin errors++; $display("FAIL div_depth: got %0d want 2", stack_depth); end
    tick();
    send(1'b1, 8'd9, 4'b0000, 8'd0, 8'd0, 8'd0);
    checks++; if (bus.resp_pc !== 8'd6) begin errors++; $display("FAIL sync1_pc: got %0d want 6", bus.resp_pc); end
    checks++; if (active_mask !== 4'b1100) begin errors++; $display("FAIL sync1_mask: got %b want 1100", active_mask); end
    checks++; if (stack_depth !== 3'd1) begin errors++; $display("FAIL sync1_depth: got %0d want 1", stack_depth); end
    tick();
    send(1'b1, 8'd6, 4'b0000, 8'd0, 8'd0, 8'd0);
    checks++; if (bus.resp_pc !== 8'd10) begin errors++; $display("FAIL sync2_pc: got %0d want 10", bus.resp_pc); end
    checks++; if (active_mask !== 4'b1111) begin errors++; $display("FAIL sync2_mask: got %b want 1111", active_mask); end
    checks++; if (stack_depth !== 3'd0) begin errors++; $display("FAIL sync2_depth: got %0d want 0", stack_depth); end
    tick();
    send(1'b1, 8'd10, 4'b0000, 8'd0, 8'd0, 8'd0);
    checks++; if (bus.resp_pc !== 8'd11) begin errors++; $display("FAIL sync3_pc: got %0d want 11", bus.resp_pc); end
    checks++; if (stack_depth !== 3'd0) begin errors++; $display("FAIL sync3_depth: got %0d want 0", stack_depth); end
    checks++; if (bus.resp_error !== 1'b0) begin errors++; $display("FAIL sync3_err: got %b want 0", bus.resp_error); end
    tick();
    send(1'b1, 8'd255, 4'b0000, 8'd0, 8'd0, 8'd0);
    checks++; if (bus.resp_pc !== 8'd0) begin errors++; $display("FAIL sync_wrap: got %0d want 0", bus.resp_pc); end
    tick();
  endtask

  task automatic test_overflow();
    do_start(3'd4);
    send(1'b0, 8'd0, 4'b0111, 8'd1, 8'd2, 8'd3);
    tick();
    checks++; if (stack_depth !== 3'd2) begin errors++; $display("FAIL ovf_d2: got %0d want 2", stack_depth); end
    tick();
    send(1'b0, 8'd1, 4'b0011, 8'd4, 8'd5, 8'd6);
    tick();
    checks++; if (stack_depth !== 3'd4) begin errors++; $display("FAIL ovf_d4: got %0d want 4", stack_depth); end
    checks++; if (active_mask !== 4'b0011) begin errors++; $display("FAIL ovf_m2: got %b want 0011", active_mask); end
    tick();
    send(1'b0, 8'd4, 4'b0001, 8'd7, 8'd8, 8'd9);
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b want 1", bus.resp_valid); end
    checks++; if (bus.resp_error !== 1'b1) begin errors++; $display("FAIL ovf_err: got %b want 1", bus.resp_error); end
    checks++; if (bus.resp_pc !== 8'd8) begin errors++; $display("FAIL ovf_pc: got %0d want 8", bus.resp_pc); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (active_mask !== 4'b0011) begin errors++; $display("FAIL ovf_mask: got %b want 0011", active_mask); end
    checks++; if (stack_depth !== 3'd4) begin errors++; $display("FAIL ovf_depth: got %0d want 4", stack_depth); end
    tick();
    checks++; if (bus.resp_error !== 1'b1) begin errors++; $display("FAIL ovf_err_hold: got %b want 1", bus.resp_error); end
    send(1'b0, 8'd8, 4'b1111, 8'd12, 8'd13, 8'd0);
    checks++; if (bus.resp_error !== 1'b0) begin errors++; $display("FAIL ovf_uni_err: got %b want 0", bus.resp_error); end
    checks++; if (bus.resp_pc !== 8'd12) begin errors++; $display("FAIL ovf_uni_pc: got %0d want 12", bus.resp_pc); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    tick();
    send(1'b1, 8'd12, 4'b0000, 8'd0, 8'd0, 8'd0);
    checks++; if (bus.resp_pc !== 8'd5) begin errors++; $display("FAIL ovf_pop_pc: got %0d want 5", bus.resp_pc); end
    checks++; if (active_mask !== 4'b0100) begin errors++; $display("FAIL ovf_pop_mask: got %b want 0100", active_mask); end
    checks++; if (stack_depth !== 3'd3) begin errors++; $display("FAIL ovf_pop_depth: got %0d want 3", stack_depth); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky2: got %b want 1", overflow); end
    tick();
    do_start(3'd4);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", overflow); end
    checks++; if (stack_depth !== 3'd0) begin errors++; $display("FAIL ovf_clear_d: got %0d want 0", stack_depth); end
  endtask

  task automatic test_start_abort();
    do_start(3'd4);
    send(1'b0, 8'd0, 4'b0011, 8'd30, 8'd31, 8'd32);
    start = 1'b1;
    thread_count = 3'd2;
    tick();
    start = 1'b0;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", bus.resp_valid); end
    checks++; if (stack_depth !== 3'd0) begin errors++; $display("FAIL abort_depth: got %0d want 0", stack_depth); end
    checks++; if (active_mask !== 4'b0011) begin errors++; $display("FAIL abort_mask: got %b want 0011", active_mask); end
    tick();
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL abort_late: got %b want 0", bus.resp_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", bus.req_ready); end
  endtask

  task automatic test_start_collision();
    start = 1'b1;
    thread_count = 3'd4;
    bus.req_type = 1'b1;
    bus.req_pc = 8'd40;
    bus.req_valid = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL coll_ready: got %b want 0", bus.req_ready); end
    tick();
    start = 1'b0;
    bus.req_valid = 1'b0;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL coll_valid: got %b want 0", bus.resp_valid); end
    checks++; if (active_mask !== 4'b1111) begin errors++; $display("FAIL coll_mask: got %b want 1111", active_mask); end
    tick();
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL coll_late: got %b want 0", bus.resp_valid); end
  endtask

  task automatic test_reset_mid_push2();
    do_start(3'd4);
    send(1'b0, 8'd0, 4'b0101, 8'd50, 8'd51, 8'd52);
    checks++; if (stack_depth !== 3'd1) begin errors++; $display("FAIL rp_pre_depth: got %0d want 1", stack_depth); end
    reset = 1'b0;
    #1;
    checks++; if (active_mask !== 4'b0000) begin errors++; $display("FAIL rp_mask: got %b want 0000", active_mask); end
    checks++; if (stack_depth !== 3'd0) begin errors++; $display("FAIL rp_depth: got %0d want 0", stack_depth); end
    checks++; if (bus.resp_pc !== 8'd0) begin errors++; $display("FAIL rp_pc: got %0d want 0", bus.resp_pc); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rp_valid: got %b want 0", bus.resp_valid); end
    checks++; if (bus.resp_error !== 1'b0) begin errors++; $display("FAIL rp_err: got %b want 0", bus.resp_error); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rp_ovf: got %b want 0", overflow); end
    tick();
    reset = 1'b1;
    tick();
    do_start(3'd3);
    checks++; if (active_mask !== 4'b0111) begin errors++; $display("FAIL rp_start_mask: got %b want 0111", active_mask); end
    checks++; if (stack_depth !== 3'd0) begin errors++; $display("FAIL rp_start_depth: got %0d want 0", stack_depth); end
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rp_start_valid: got %b want 0", bus.resp_valid); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    start = 1'b0;
    thread_count = 3'd0;
    bus.req_valid = 1'b0;
    bus.req_type = 1'b0;
    bus.req_pc = '0;
    bus.taken_mask = '0;
    bus.taken_pc = '0;
    bus.not_taken_pc = '0;
    bus.reconv_pc = '0;
    test_reset();
    test_start_mask();
    test_uniform();
    test_divergence();
    test_overflow();
    test_start_abort();
    test_start_collision();
    test_reset_mid_push2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
